sprite_fetch_arbiter: RTL and testbench

//  Shares the single-read-port sprite ROM (20 tiles x 24x24 px, 5-bit palette index,
//  11520 words, 1-cycle registered read) between NUM_REQ pixel requesters.
//  Req 0 is the VGA playfield renderer (fixed highest priority); the others are

---
 rtl/sprite_fetch_arbiter_pkg.sv | 17 +
 rtl/sprite_fetch_arbiter_if.sv | 19 +
 rtl/sprite_fetch_arbiter_addr_calc.sv | 27 ++
 rtl/sprite_fetch_arbiter.sv | 118 +++++++++++
 tb/tb_sprite_fetch_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/sprite_fetch_arbiter_pkg.sv
// Shared constants and types for the sprite ROM fetch arbiter.
// Sprite ROM: 20 tiles of 24x24 px, 5-bit palette index per word, 11520 words.
package sprite_fetch_arbiter_pkg;
  localparam int TILE_W    = 24;
  localparam int TILE_H    = 24;
  localparam int NUM_TILES = 20;
  localparam int ROM_DEPTH = TILE_W * TILE_H * NUM_TILES;
  localparam int ROM_AW    = $clog2(ROM_DEPTH);
  localparam int PIX_W     = 5;
  localparam int CRD_W     = 5;

  typedef struct packed {
    logic [CRD_W-1:0] tile;
    logic [CRD_W-1:0] px;
    logic [CRD_W-1:0] py;
  } sprite_coord_t;
endpackage

// File: rtl/sprite_fetch_arbiter_if.sv
// Requester-side bus of the sprite fetch arbiter.
//   req       requester -> arbiter, held until gnt
//   coord     per-requester {tile, px, py}, sampled in the gnt cycle
//   gnt       arbiter -> requester, one-hot accept pulse
//   rsp_valid one-hot response tag, 3 cycles after gnt
//   rsp_data  palette index, valid with rsp_valid
// master = requesters, slave = arbiter.
interface sprite_fetch_arbiter_if import sprite_fetch_arbiter_pkg::*; #(
  parameter int NUM_REQ = 3
);
  logic          [NUM_REQ-1:0] req;
  sprite_coord_t [NUM_REQ-1:0] coord;
  logic          [NUM_REQ-1:0] gnt;
  logic          [NUM_REQ-1:0] rsp_valid;
  logic          [PIX_W-1:0]   rsp_data;

  modport master (output req, coord, input gnt, rsp_valid, rsp_data);
  modport slave  (input req, coord, output gnt, rsp_valid, rsp_data);
endinterface

// File: rtl/sprite_fetch_arbiter_addr_calc.sv
// sprite_addr_calc: combinational (tile, px, py) -> ROM word address.
//   coord_i    tile/px/py of one requester
//   addr_o     tile*576 + py*24 + px, wrapped to 14 bits
//   in_range_o coordinate legal (only evaluated when ADDR_CHECK_EN is
//              defined, otherwise constant 1)
module sprite_addr_calc import sprite_fetch_arbiter_pkg::*; (
  input  sprite_coord_t     coord_i,
  output logic [ROM_AW-1:0] addr_o,
  output logic              in_range_o
);
  logic [ROM_AW-1:0] t, x, y;

  assign t = ROM_AW'(coord_i.tile);
  assign x = ROM_AW'(coord_i.px);
  assign y = ROM_AW'(coord_i.py);

  // 576 = 512 + 64, 24 = 16 + 8; 14-bit sum wraps naturally
  assign addr_o = (t << 9) + (t << 6) + (y << 4) + (y << 3) + x;

`ifdef ADDR_CHECK_EN
  assign in_range_o = (coord_i.tile < CRD_W'(NUM_TILES)) &&
                      (coord_i.px   < CRD_W'(TILE_W))    &&
                      (coord_i.py   < CRD_W'(TILE_H));
`else
  assign in_range_o = 1'b1;
`endif
endmodule

// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: shares the single-port sprite ROM between NUM_REQ
// pixel requesters. Req 0 has fixed priority, the rest are round-robin; a
// low-priority requester waiting STARVE_MAX cycles overrides req 0.
// Ports:
//   clk_i, rst_n_i  clock, async active-low reset
//   bus             requester bus (slave modport)
//   rom_addr_o      registered ROM read address
//   rom_data_i      ROM data, one cycle after rom_addr_o
//   addr_err_o      sticky out-of-range flag
// Optional feature macro: ADDR_CHECK_EN (range checking; undefined -> no
// check, addresses wrap, addr_err_o stays 0).
// Latency gnt -> rsp_valid is a fixed 3 cycles, no back-pressure.
module sprite_fetch_arbiter import sprite_fetch_arbiter_pkg::*; #(
  parameter int NUM_REQ    = 3,
  parameter int STARVE_MAX = 15
)(
  input  logic               clk_i,
  input  logic               rst_n_i,
  sprite_fetch_arbiter_if.slave bus,
  output logic [ROM_AW-1:0]  rom_addr_o,
  input  logic [PIX_W-1:0]   rom_data_i,
  output logic               addr_err_o
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int SW     = $clog2(STARVE_MAX + 1);
  localparam int STAGES = 3;

  logic [NUM_REQ-1:0][ROM_AW-1:0] lane_addr;
  logic [NUM_REQ-1:0]             lane_ok;

  logic [IDX_W-1:0]  rr_ptr_q;
  logic [SW-1:0]     starve_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              err_q;
  logic [PIX_W-1:0]  rsp_data_q;
  // stage 1: ROM address cycle, stage 2: ROM data cycle, stage 3: response
  logic [STAGES:1][NUM_REQ-1:0] vld_pipe_q;
  logic [STAGES-1:1]            bad_pipe_q;

  logic [NUM_REQ-1:0] gnt;
  logic               rr_hit, lo_gnt, lo_wait, sel_ok, bad;
  logic [IDX_W-1:0]   rr_idx, cand;
  logic [ROM_AW-1:0]  sel_addr;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    sprite_addr_calc u_calc (
      .coord_i    (bus.coord[k]),
      .addr_o     (lane_addr[k]),
      .in_range_o (lane_ok[k])
    );
  end

  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    // scan low-priority requesters starting at rr_ptr_q, wrapping within 1..NUM_REQ-1
    for (int i = 0; i < NUM_REQ - 1; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) - 1 + i) % (NUM_REQ - 1) + 1);
      if (!rr_hit && bus.req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end

    gnt = '0;
    if (rr_hit && starve_q == SW'(STARVE_MAX)) gnt[rr_idx] = 1'b1;
    else if (bus.req[0])                       gnt[0]      = 1'b1;
    else if (rr_hit)                           gnt[rr_idx] = 1'b1;

    lo_gnt  = |gnt[NUM_REQ-1:1];
    lo_wait = (|bus.req[NUM_REQ-1:1]) & ~lo_gnt;

    sel_addr = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr = sel_addr | lane_addr[k];
        sel_ok   = sel_ok | lane_ok[k];
      end
    end
    bad = (|gnt) & ~sel_ok;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q   <= IDX_W'(1);
      starve_q   <= '0;
      rom_addr_q <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      vld_pipe_q <= '0;
      bad_pipe_q <= '0;
    end else begin
      if (lo_gnt) begin
        starve_q <= '0;
        rr_ptr_q <= (rr_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : rr_idx + IDX_W'(1);
      end else if (lo_wait && starve_q != SW'(STARVE_MAX)) begin
        starve_q <= starve_q + SW'(1);
      end

      // a rejected coordinate leaves the ROM address where it was
      if ((|gnt) && !bad) rom_addr_q <= sel_addr;
      if (bad)            err_q      <= 1'b1;

      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], gnt};
      bad_pipe_q <= {bad_pipe_q[STAGES-2:1], bad};
      if (|vld_pipe_q[STAGES-1])
        rsp_data_q <= bad_pipe_q[STAGES-1] ? '0 : rom_data_i;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rsp_valid = vld_pipe_q[STAGES];
  assign bus.rsp_data  = rsp_data_q;
  assign rom_addr_o    = rom_addr_q;
  assign addr_err_o    = err_q;
endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Directed bench for sprite_fetch_arbiter with a behavioural ROM whose word
// at address a is a[4:0] ^ a[9:5] ^ a[13:10].
module tb_sprite_fetch_arbiter;
  import sprite_fetch_arbiter_pkg::*;
  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic              addr_err;
  int checks = 0;
  int errors = 0;

  logic [NR-1:0]     g2 [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
  logic [ROM_AW-1:0] a2 [4] = '{14'd576, 14'd1728, 14'd576, 14'd1728};

  sprite_fetch_arbiter_if #(.NUM_REQ(NR)) bus ();

  sprite_fetch_arbiter #(.NUM_REQ(NR), .STARVE_MAX(15)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .addr_err_o (addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [PIX_W-1:0] rom_word(input logic [ROM_AW-1:0] a);
    return a[4:0] ^ a[9:5] ^ {1'b0, a[13:10]};
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setc(input int k, input int t, input int x, input int y);
    bus.coord[k].tile = CRD_W'(t);
    bus.coord[k].px   = CRD_W'(x);
    bus.coord[k].py   = CRD_W'(y);
  endtask

  initial begin
    bus.req = '0;
    for (int k = 0; k < NR; k++) setc(k, 0, 0, 0);

    // reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_gnt",  32'(bus.gnt), 0);
    chk("rst_rv",   32'(bus.rsp_valid), 0);
    chk("rst_rd",   32'(bus.rsp_data), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_err",  32'(addr_err), 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: single req0 fetch, tile 2 px 3 py 1 -> 1179
    @(negedge clk); bus.req = 3'b001; setc(0, 2, 3, 1); #1;
    chk("t1_gnt", 32'(bus.gnt), 1);
    @(negedge clk); bus.req = '0; #1;
    chk("t1_addr", 32'(rom_addr), 1179);
    chk("t1_nognt", 32'(bus.gnt), 0);
    @(negedge clk); #1;
    chk("t1_rv_n2", 32'(bus.rsp_valid), 0);
    @(negedge clk); #1;
    chk("t1_rv", 32'(bus.rsp_valid), 1);
    chk("t1_rd", 32'(bus.rsp_data), 32'(rom_word(14'd1179)));
    @(negedge clk); #1;
    chk("t1_rv_off", 32'(bus.rsp_valid), 0);

    // 2: req1/req2 alternate round-robin
    setc(1, 1, 0, 0); setc(2, 3, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.req = (i < 4) ? 3'b110 : 3'b000;
      #1;
      if (i < 4) chk("t2_gnt", 32'(bus.gnt), 32'(g2[i]));
      if (i >= 3 && i < 7) begin
        chk("t2_rv", 32'(bus.rsp_valid), 32'(g2[i-3]));
        chk("t2_rd", 32'(bus.rsp_data), 32'(rom_word(a2[i-3])));
      end
      if (i == 7) chk("t2_idle", 32'(bus.rsp_valid), 0);
    end

    // 3: starvation, req0+req1 held -> 15x gnt0 then 1x gnt1
    setc(0, 0, 0, 0); setc(1, 0, 1, 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); bus.req = 3'b011; #1;
      chk("t3_gnt", 32'(bus.gnt), (i % 16 == 15) ? 2 : 1);
    end
    @(negedge clk); bus.req = '0;
    repeat (4) @(negedge clk);

    // 4: back-to-back req0, tile 19 row 5, px 0..23
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (i < 24) begin bus.req = 3'b001; setc(0, 19, i, 5); end
      else bus.req = '0;
      #1;
      if (i < 24) chk("t4_gnt", 32'(bus.gnt), 1);
      if (i >= 1 && i <= 24) chk("t4_addr", 32'(rom_addr), 11064 + i - 1);
      if (i < 3) chk("t4_rv_idle", 32'(bus.rsp_valid), 0);
      else begin
        chk("t4_rv", 32'(bus.rsp_valid), 1);
        chk("t4_rd", 32'(bus.rsp_data), 32'(rom_word(ROM_AW'(11064 + i - 3))));
      end
    end

    // 5: tile 20 on req1, then a legal req0 fetch of address 5
    setc(1, 20, 0, 0);
    @(negedge clk); bus.req = 3'b010; #1;
    chk("t5_gnt", 32'(bus.gnt), 2);
    @(negedge clk); bus.req = 3'b001; setc(0, 0, 5, 0); #1;
    chk("t5_gnt0", 32'(bus.gnt), 1);
`ifdef ADDR_CHECK_EN
    chk("t5_err", 32'(addr_err), 1);
    chk("t5_addr", 32'(rom_addr), 11087);
`else
    chk("t5_err", 32'(addr_err), 0);
    chk("t5_addr", 32'(rom_addr), 11520);
`endif
    @(negedge clk); bus.req = '0; #1;
    chk("t5_addr2", 32'(rom_addr), 5);
    @(negedge clk); #1;
    chk("t5_rv", 32'(bus.rsp_valid), 2);
`ifdef ADDR_CHECK_EN
    chk("t5_rd", 32'(bus.rsp_data), 0);
`else
    chk("t5_rd", 32'(bus.rsp_data), 32'(rom_word(14'd11520)));
`endif
    @(negedge clk); #1;
    chk("t5_rv2", 32'(bus.rsp_valid), 1);
    chk("t5_rd2", 32'(bus.rsp_data), 5);
    repeat (3) @(negedge clk);
    #1;
`ifdef ADDR_CHECK_EN
    chk("t5_sticky", 32'(addr_err), 1);
`else
    chk("t5_sticky", 32'(addr_err), 0);
`endif

    // 6: reset one cycle after a grant drops the in-flight response
    setc(0, 1, 1, 1);
    @(negedge clk); bus.req = 3'b001; #1;
    chk("t6_gnt", 32'(bus.gnt), 1);
    @(negedge clk); bus.req = '0; rst_n = 1'b0; #1;
    chk("t6_gnt_r",  32'(bus.gnt), 0);
    chk("t6_rv_r",   32'(bus.rsp_valid), 0);
    chk("t6_rd_r",   32'(bus.rsp_data), 0);
    chk("t6_addr_r", 32'(rom_addr), 0);
    chk("t6_err_r",  32'(addr_err), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t6_rv_after", 32'(bus.rsp_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
